// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN short-circuits divide-by-zero and signed-overflow requests.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [1:0]      div_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_VAL   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [5:0]      LAST_ITER = 6'(XLEN - 1);

    state_t          state_reg;
    logic [5:0]      count_reg;
    logic [XLEN-1:0] quot_reg;
    logic [XLEN-1:0] rem_reg;
    logic [XLEN-1:0] divisor_reg;
    logic [XLEN-1:0] a_raw_reg;
    logic [XLEN-1:0] result_reg;
    logic            neg_q_reg;
    logic            neg_r_reg;
    logic            want_rem_reg;
    logic            div_zero_reg;
    logic            ovf_reg;

    logic            accept;
    logic            signed_op;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            q_bit;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quot_next;
    logic [XLEN-1:0] final_value;
    logic            last_iter;

    assign in_ready  = (state_reg == IDLE) && !flush;
    assign accept    = in_valid && in_ready;
    assign busy      = (state_reg != IDLE);
    assign out_valid = (state_reg == DONE);
    assign result    = out_valid ? result_reg : '0;

    // div_op[0] selects the unsigned variants
    assign signed_op = !div_op[0];
    assign a_neg     = signed_op && a[XLEN-1];
    assign b_neg     = signed_op && b[XLEN-1];

    // Partial remainder stays below the divisor, so XLEN+1 bits hold the trial subtraction
    // and its top bit is the borrow.
    assign shifted   = {rem_reg, quot_reg[XLEN-1]};
    assign diff      = shifted - {1'b0, divisor_reg};
    assign q_bit     = !diff[XLEN];
    assign rem_next  = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quot_next = {quot_reg[XLEN-2:0], q_bit};

    always_comb begin
        final_value = '0;
        if (div_zero_reg) begin
            final_value = want_rem_reg ? a_raw_reg : '1;
        end else if (ovf_reg) begin
            final_value = want_rem_reg ? '0 : MIN_VAL;
        end else if (want_rem_reg) begin
            final_value = neg_r_reg ? -rem_next : rem_next;
        end else begin
            final_value = neg_q_reg ? -quot_next : quot_next;
        end
    end

`ifdef DIV_EARLY_OUT_EN
    // Special cases spend a single CALC cycle so the result appears one edge after acceptance.
    assign last_iter = (count_reg == LAST_ITER) || div_zero_reg || ovf_reg;
`else
    assign last_iter = (count_reg == LAST_ITER);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            quot_reg     <= '0;
            rem_reg      <= '0;
            divisor_reg  <= '0;
            a_raw_reg    <= '0;
            result_reg   <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            want_rem_reg <= 1'b0;
            div_zero_reg <= 1'b0;
            ovf_reg      <= 1'b0;
        end else if (flush) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        quot_reg     <= a_neg ? -a : a;
                        divisor_reg  <= b_neg ? -b : b;
                        rem_reg      <= '0;
                        a_raw_reg    <= a;
                        neg_q_reg    <= a_neg ^ b_neg;
                        neg_r_reg    <= a_neg;
                        want_rem_reg <= div_op[1];
                        div_zero_reg <= (b == '0);
                        ovf_reg      <= signed_op && (a == MIN_VAL) && (b == '1);
                        count_reg    <= '0;
                        state_reg    <= CALC;
                    end
                end
                CALC: begin
                    quot_reg  <= quot_next;
                    rem_reg   <= rem_next;
                    count_reg <= count_reg + 6'd1;
                    if (last_iter) begin
                        result_reg <= final_value;
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, randomized ops against an
// arithmetic reference, back-pressure, and reset/flush aborts.
module tb_div_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] a = '0;
    logic [XLEN-1:0] b = '0;
    logic [1:0]      div_op = 2'b00;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] result;
    logic            busy;

    int total = 0;
    int bad = 0;

    div_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .div_op    (div_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit integer arithmetic (truncating division), plus the b==0 rule.
    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint r;
        if (y == 32'd0) return op[1] ? x : 32'hFFFF_FFFF;
        if (!op[0]) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'({32'd0, x});
            sy = longint'({32'd0, y});
        end
        r = op[1] ? (sx % sy) : (sx / sy);
        return r[31:0];
    endfunction

    function automatic int exp_latency(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
`ifdef DIV_EARLY_OUT_EN
        if (y == 32'd0 || (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) return 1;
`endif
        return XLEN;
    endfunction

    // Issues one request starting just after a negedge; returns at the negedge where out_valid
    // is first seen (plus one consume cycle if out_ready is high).
    task automatic do_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output int lat);
        div_op   = op;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        div_op   = 2'($urandom);
        lat = 0;
        res = '0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid === 1'b1) break;
        end
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL result_timeout: out_valid=%b after %0d cycles required 1", out_valid, lat);
        end else begin
            res = result;
        end
        if (out_ready) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        $display("reset in_ready=%b out_valid=%b busy=%b result=%h", in_ready, out_valid, busy, result);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result: got %h required 0", result); end
    endtask

    task automatic test_directed();
        logic [1:0]  t_op  [10];
        logic [31:0] t_a   [10];
        logic [31:0] t_b   [10];
        logic [31:0] t_exp [10];
        logic [31:0] res;
        int          lat;
        int          want_lat;
        t_op  = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b01, 2'b11, 2'b10, 2'b00, 2'b10, 2'b00};
        t_a   = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5,
                  32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB};
        t_b   = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd0, 32'd0,
                  32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        t_exp = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5,
                  32'hFFFF_FFFB, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            do_op(t_op[i], t_a[i], t_b[i], res, lat);
            want_lat = exp_latency(t_op[i], t_a[i], t_b[i]);
            $display("directed %0d op=%0d a=%h b=%h result=%h lat=%0d", i, t_op[i], t_a[i], t_b[i], res, lat);
            total++;
            if (res !== t_exp[i]) begin
                bad++;
                $display("FAIL directed_result[%0d]: got %h required %h", i, res, t_exp[i]);
            end
            total++;
            if (lat != want_lat) begin
                bad++;
                $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, want_lat);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] res;
        logic [31:0] want;
        int          lat;
        int          mode;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            op   = 2'($urandom_range(0, 3));
            x    = $urandom;
            mode = $urandom_range(0, 6);
            case (mode)
                0: y = 32'd0;
                1: y = 32'($urandom_range(1, 15));
                2: y = -32'($urandom_range(1, 15));
                3: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                default: y = $urandom;
            endcase
            want = ref_model(op, x, y);
            do_op(op, x, y, res, lat);
            $display("random %0d op=%0d a=%h b=%h result=%h lat=%0d", i, op, x, y, res, lat);
            total++;
            if (res !== want) begin
                bad++;
                $display("FAIL random_result[%0d]: got %h required %h", i, res, want);
            end
            total++;
            if (lat != exp_latency(op, x, y)) begin
                bad++;
                $display("FAIL random_latency[%0d]: got %0d required %0d", i, lat, exp_latency(op, x, y));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        int          lat;
        out_ready = 1'b0;
        do_op(2'b01, 32'd1000, 32'd3, res, lat);
        // A competing request is presented throughout the stall and at the consume edge.
        in_valid = 1'b1;
        a        = 32'd77;
        b        = 32'd5;
        div_op   = 2'b01;
        for (int i = 0; i < 10; i++) begin
            $display("stall %0d out_valid=%b result=%h in_ready=%b", i, out_valid, result, in_ready);
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_out_valid[%0d]: got %b required 1", i, out_valid); end
            total++; if (result !== 32'd333) begin bad++; $display("FAIL stall_result[%0d]: got %h required %h", i, result, 32'd333); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d]: got %b required 0", i, in_ready); end
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        $display("consume out_valid=%b in_ready=%b busy=%b", out_valid, in_ready, busy);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL consume_out_valid: got %b required 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL consume_in_ready: got %b required 1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL consume_no_accept: busy=%b required 0", busy); end
    endtask

    task automatic test_abort(input bit use_rst);
        logic [31:0] res;
        logic [31:0] want;
        int          lat;
        bit          seen;
        out_ready = 1'b1;
        div_op    = 2'b01;
        a         = 32'd123456;
        b         = 32'd10;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before: got %b required 1", busy); end
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        $display("abort rst=%0b out_valid=%b in_ready=%b busy=%b result=%h", use_rst, out_valid, in_ready, busy, result);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_out_valid: got %b required 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_in_ready: got %b required 1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b required 0", busy); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL abort_result: got %h required 0", result); end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL abort_no_result: out_valid seen=1 required 0"); end
        want = ref_model(2'b00, 32'hFFFF_0000, 32'd7);
        do_op(2'b00, 32'hFFFF_0000, 32'd7, res, lat);
        $display("recover op=0 a=ffff0000 b=7 result=%h lat=%0d", res, lat);
        total++; if (res !== want) begin bad++; $display("FAIL abort_recover: got %h required %h", res, want); end
    endtask

    task automatic test_flush_idle();
        flush    = 1'b1;
        in_valid = 1'b1;
        div_op   = 2'b01;
        a        = 32'd9;
        b        = 32'd3;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_idle_in_ready: got %b required 0", in_ready); end
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        $display("flush_idle busy=%b out_valid=%b", busy, out_valid);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_idle_accept: busy=%b required 0", busy); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_abort(1'b1);
        test_abort(1'b0);
        test_flush_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
